// File: rtl/wt_hybrid_cache_pkg.sv
// Shared types and helpers for the hybrid write-through dcache request path.
// Holds the port arbiter state encoding and port-index sizing.
package wt_hybrid_cache_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FLUSH,
    DONE
  } arb_state_e;

  // Width of a port index; a single port still needs one bit to carry it.
  function automatic int unsigned arb_idx_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  localparam int unsigned ARB_NUM_PORTS  = 3;
  localparam int unsigned ARB_PORT_IDX_W = arb_idx_w(ARB_NUM_PORTS);

endpackage

// File: rtl/wt_hybche_id_fifo.sv
// In-order FIFO holding the requester index of every in-flight memory access.
// Depth must be a power of two so the pointers wrap naturally.
module wt_hybche_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     usage_q;
  logic               push_ok, pop_ok;

  assign full_o  = (usage_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   usage_q <= usage_q + 1'b1;
        2'b01:   usage_q <= usage_q - 1'b1;
        default: usage_q <= usage_q;
      endcase
    end
  end

  // Storage is pure data; validity is tracked by the pointers above.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wt_hybche_port_arb.sv
// Round-robin scheduler sharing one dcache access port between core requesters,
// routing in-order responses back and sequencing mode switches and flushes.
module wt_hybche_port_arb
  import wt_hybrid_cache_pkg::*;
#(
  parameter int unsigned NUM_PORTS            = ARB_NUM_PORTS,
  parameter int unsigned ADDR_WIDTH           = 56,
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned MAX_OUTST            = 4,
  parameter bit          FLUSH_ON_MODE_CHANGE = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              use_set_assoc_mode_i,
  input  logic                              flush_i,
  output logic                              flush_ack_o,
  input  logic [NUM_PORTS-1:0]              port_req_i,
  input  logic [NUM_PORTS-1:0]              port_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_be_i,
  output logic [NUM_PORTS-1:0]              port_gnt_o,
  output logic [NUM_PORTS-1:0]              port_rvalid_o,
  output logic [DATA_WIDTH-1:0]             port_rdata_o,
  output logic                              mem_req_o,
  input  logic                              mem_gnt_i,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  output logic                              mem_fa_mode_o,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  output logic                              mem_flush_req_o,
  input  logic                              mem_flush_ack_i,
  output logic                              busy_o
);

  localparam int unsigned IDX_W = arb_idx_w(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  arb_state_e       state_q, state_d;
  logic             fa_mode_q;
  logic             flush_pend_q, flush_pend_d;
  logic             ack_mask_q;
  logic [IDX_W-1:0] rr_q, rr_next;
  logic [IDX_W-1:0] winner;
  logic             winner_vld;
  logic [IDX_W:0]   cand;
  logic [CNT_W-1:0] count;
  logic             trigger, eligible, grant, pop;
  logic             fifo_empty, fifo_full;
  logic [IDX_W-1:0] head_idx;

  // A mode mismatch means the requested fully-assoc flag differs from the committed one.
  // The first RUN cycle after an acknowledged flush ignores flush_i so a requester
  // that drops it one cycle after the ack does not start a second flush.
  assign trigger  = (state_q == RUN) &&
                    ((flush_i && !ack_mask_q) || (use_set_assoc_mode_i == fa_mode_q));
  assign eligible = (state_q == RUN) && !trigger && (count < CNT_W'(MAX_OUTST));

  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!winner_vld && port_req_i[cand[IDX_W-1:0]]) begin
        winner_vld = 1'b1;
        winner     = cand[IDX_W-1:0];
      end
    end
  end

  assign rr_next   = (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
  assign mem_req_o = eligible && winner_vld;
  assign grant     = mem_req_o && mem_gnt_i;
  assign pop       = mem_rvalid_i && !fifo_empty;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    port_gnt_o  = '0;
    if (mem_req_o) begin
      mem_we_o    = port_we_i[winner];
      mem_addr_o  = port_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_o = port_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
      mem_be_o    = port_be_i[winner*BE_W +: BE_W];
    end
    if (grant) port_gnt_o[winner] = 1'b1;
  end

  always_comb begin
    port_rvalid_o = '0;
    port_rdata_o  = '0;
    if (pop) begin
      port_rvalid_o[head_idx] = 1'b1;
      port_rdata_o            = mem_rdata_i;
    end
  end

  wt_hybche_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (count)
  );

  always_comb begin
    state_d         = state_q;
    flush_pend_d    = flush_pend_q;
    flush_ack_o     = 1'b0;
    mem_flush_req_o = 1'b0;
    case (state_q)
      RUN: begin
        if (trigger) begin
          state_d      = DRAIN;
          flush_pend_d = flush_i && !ack_mask_q;
        end
      end
      DRAIN: begin
        flush_pend_d = flush_pend_q | flush_i;
        if (count == '0) begin
          state_d = (flush_pend_d || FLUSH_ON_MODE_CHANGE) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        mem_flush_req_o = 1'b1;
        flush_pend_d    = flush_pend_q | flush_i;
        if (mem_flush_ack_i) state_d = DONE;
      end
      DONE: begin
        flush_ack_o  = flush_pend_q;
        flush_pend_d = 1'b0;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      fa_mode_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      ack_mask_q   <= 1'b0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      ack_mask_q   <= (state_q == DONE) && flush_pend_q;
      if (state_q == DONE) fa_mode_q <= ~use_set_assoc_mode_i;
      if (grant) rr_q <= rr_next;
    end
  end

  assign mem_fa_mode_o = fa_mode_q;
  assign busy_o        = (count != '0) || (state_q != RUN);

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !fifo_empty);
  grant_needs_space: assert property (
    @(posedge clk_i) disable iff (!rst_ni) grant |-> !fifo_full);
`endif

endmodule
